// File: rtl/v2f_seq_mul_limb.sv
// Sequential WIDTH x WIDTH unsigned multiplier that issues one 16x16->32 partial
// product per cycle, walking product columns from least to most significant and
// folding each column into a 40-bit accumulator. Truncated mode yields the low
// WIDTH bits of A*B; full mode yields the whole 2*WIDTH-bit product.
module v2f_seq_mul_limb #(
    parameter int WIDTH        = 64,
    parameter int FULL_PRODUCT = 0,
    localparam int Y_WIDTH     = (FULL_PRODUCT != 0) ? 2 * WIDTH : WIDTH
) (
    input  logic               CLK,
    input  logic               SRST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [Y_WIDTH-1:0] Y,
    output logic               BUSY
);

    localparam int L    = WIDTH / 16;
    localparam int KMAX = (FULL_PRODUCT != 0) ? 2 * L - 2 : L - 1;
    localparam int YL   = Y_WIDTH / 16;
    localparam logic [5:0] LAST_LIMB = 6'(L - 1);
    localparam logic [5:0] LAST_COL  = 6'(KMAX);

    if ((WIDTH % 16) != 0 || WIDTH < 16 || WIDTH > 256) begin : g_width_check
        $error("v2f_seq_mul_limb: WIDTH must be a multiple of 16 in 16..256");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [5:0]         i_idx;
    logic [5:0]         k_idx;
    logic [39:0]        acc;
    logic [Y_WIDTH-1:0] y_reg;
    logic               out_valid_reg;
    logic               busy_reg;
    logic               in_ready_reg;

    logic [5:0]         j_idx;
    logic [15:0]        a_limb;
    logic [15:0]        b_limb;
    logic [31:0]        product;
    logic [39:0]        sum;
    logic [5:0]         i_max;
    logic               col_last;
    logic               op_last;
    logic [5:0]         k_next;
    logic [5:0]         i_start;
    logic [Y_WIDTH-1:0] y_col;

    // Select the current limb pair, form its partial product and work out where the walk goes next.
    always_comb begin
        a_limb = '0;
        b_limb = '0;
        j_idx  = k_idx - i_idx;
        for (int n = 0; n < L; n++) begin
            if (i_idx == 6'(n)) a_limb = a_reg[16*n +: 16];
            if (j_idx == 6'(n)) b_limb = b_reg[16*n +: 16];
        end
        product  = 32'(a_limb) * 32'(b_limb);
        sum      = acc + {8'd0, product};
        i_max    = (k_idx < LAST_LIMB) ? k_idx : LAST_LIMB;
        col_last = (i_idx == i_max);
        op_last  = col_last && (k_idx == LAST_COL);
        k_next   = k_idx + 6'd1;
        i_start  = (k_next > LAST_LIMB) ? (k_next - LAST_LIMB) : 6'd0;
        y_col    = y_reg;
        for (int n = 0; n < YL; n++) begin
            if (k_idx == 6'(n)) y_col[16*n +: 16] = sum[15:0];
        end
        if (FULL_PRODUCT != 0 && op_last) y_col[Y_WIDTH-1 -: 16] = sum[31:16];
    end

    // Handshake FSM plus column walk; a column's low 16 bits retire into Y and the rest carries on.
    always_ff @(posedge CLK) begin
        if (SRST) begin
            state         <= S_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            i_idx         <= '0;
            k_idx         <= '0;
            acc           <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        a_reg        <= A;
                        b_reg        <= B;
                        i_idx        <= '0;
                        k_idx        <= '0;
                        acc          <= '0;
                        state        <= S_BUSY;
                        busy_reg     <= 1'b1;
                        in_ready_reg <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (col_last) begin
                        y_reg <= y_col;
                        acc   <= {16'd0, sum[39:16]};
                        if (op_last) begin
                            state         <= S_DONE;
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end else begin
                            k_idx <= k_next;
                            i_idx <= i_start;
                        end
                    end else begin
                        acc   <= sum;
                        i_idx <= i_idx + 6'd1;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        state         <= S_IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    busy_reg      <= 1'b0;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_reg;
    assign OUT_VALID = out_valid_reg;
    assign BUSY      = busy_reg;
    assign Y         = y_reg;

endmodule

// File: tb/tb_v2f_seq_mul_limb.sv
// Self-checking bench for v2f_seq_mul_limb: five instances cover truncated and
// full modes at several widths; expected products come from a wide native multiply
// pushed to a scoreboard queue and popped when the DUT presents a result.
module tb_v2f_seq_mul_limb;

    logic clk = 1'b0;
    logic srst;
    logic [4:0] in_valid;
    logic [4:0] out_ready;
    logic [4:0] in_ready;
    logic [4:0] out_valid;
    logic [4:0] busy;
    logic [95:0] a_in [5];
    logic [95:0] b_in [5];
    logic [63:0]  y0;
    logic [127:0] y1;
    logic [15:0]  y2;
    logic [31:0]  y3;
    logic [191:0] y4;

    int wid [5] = '{64, 64, 16, 32, 96};
    int ful [5] = '{0, 1, 0, 0, 1};

    int errors = 0;
    int checks = 0;
    longint cycle_cnt = 0;
    logic [191:0] sb_q [$];

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure issue intervals.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    v2f_seq_mul_limb #(.WIDTH(64), .FULL_PRODUCT(0)) u_t64 (
        .CLK(clk), .SRST(srst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .A(a_in[0][63:0]), .B(b_in[0][63:0]), .OUT_VALID(out_valid[0]),
        .OUT_READY(out_ready[0]), .Y(y0), .BUSY(busy[0]));

    v2f_seq_mul_limb #(.WIDTH(64), .FULL_PRODUCT(1)) u_f64 (
        .CLK(clk), .SRST(srst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .A(a_in[1][63:0]), .B(b_in[1][63:0]), .OUT_VALID(out_valid[1]),
        .OUT_READY(out_ready[1]), .Y(y1), .BUSY(busy[1]));

    v2f_seq_mul_limb #(.WIDTH(16), .FULL_PRODUCT(0)) u_t16 (
        .CLK(clk), .SRST(srst), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
        .A(a_in[2][15:0]), .B(b_in[2][15:0]), .OUT_VALID(out_valid[2]),
        .OUT_READY(out_ready[2]), .Y(y2), .BUSY(busy[2]));

    v2f_seq_mul_limb #(.WIDTH(32), .FULL_PRODUCT(0)) u_t32 (
        .CLK(clk), .SRST(srst), .IN_VALID(in_valid[3]), .IN_READY(in_ready[3]),
        .A(a_in[3][31:0]), .B(b_in[3][31:0]), .OUT_VALID(out_valid[3]),
        .OUT_READY(out_ready[3]), .Y(y3), .BUSY(busy[3]));

    v2f_seq_mul_limb #(.WIDTH(96), .FULL_PRODUCT(1)) u_f96 (
        .CLK(clk), .SRST(srst), .IN_VALID(in_valid[4]), .IN_READY(in_ready[4]),
        .A(a_in[4]), .B(b_in[4]), .OUT_VALID(out_valid[4]),
        .OUT_READY(out_ready[4]), .Y(y4), .BUSY(busy[4]));

    function automatic logic [191:0] yget(input int s);
        case (s)
            0: return 192'(y0);
            1: return 192'(y1);
            2: return 192'(y2);
            3: return 192'(y3);
            default: return y4;
        endcase
    endfunction

    function automatic logic [191:0] model(input int s, input logic [95:0] a, input logic [95:0] b);
        logic [95:0]  in_mask;
        logic [191:0] am;
        logic [191:0] bm;
        logic [191:0] prod;
        int yw;
        in_mask = (96'd1 << wid[s]) - 96'd1;
        am = 192'(a & in_mask);
        bm = 192'(b & in_mask);
        prod = am * bm;
        yw = (ful[s] != 0) ? 2 * wid[s] : wid[s];
        if (yw < 192) prod = prod & ((192'd1 << yw) - 192'd1);
        return prod;
    endfunction

    function automatic int p_of(input int s);
        int l;
        l = wid[s] / 16;
        return (ful[s] != 0) ? l * l : l * (l + 1) / 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Push the expected product, hand over one operand pair, then wait for and check the result.
    task automatic apply_stimulus(input int s, input logic [95:0] a, input logic [95:0] b,
                                  input string tag, input bit release_out);
        int waited;
        logic [191:0] exp;
        sb_q.push_back(model(s, a, b));
        check_output({tag, "_in_ready_idle"}, 192'(in_ready[s]), 192'(1));
        a_in[s] = a;
        b_in[s] = b;
        in_valid[s] = 1'b1;
        out_ready[s] = 1'b0;
        tick();
        in_valid[s] = 1'b0;
        a_in[s] = ~a;
        b_in[s] = ~b;
        check_output({tag, "_busy"}, 192'(busy[s]), 192'(1));
        check_output({tag, "_in_ready_busy"}, 192'(in_ready[s]), 192'(0));
        waited = 0;
        while (!out_valid[s] && waited < 2000) begin
            tick();
            waited++;
        end
        check_output({tag, "_latency"}, 192'(waited), 192'(p_of(s)));
        exp = sb_q.pop_front();
        check_output({tag, "_y"}, yget(s), exp);
        if (release_out) begin
            out_ready[s] = 1'b1;
            tick();
            out_ready[s] = 1'b0;
            check_output({tag, "_out_valid_drop"}, 192'(out_valid[s]), 192'(0));
            check_output({tag, "_in_ready_back"}, 192'(in_ready[s]), 192'(1));
        end
    endtask

    // One cycle of the back-to-back run on the 96-bit full instance, retiring any result seen.
    task automatic step96(inout int received);
        logic [191:0] exp;
        tick();
        if (out_valid[4]) begin
            check_output("t5_result_expected", 192'(sb_q.size() != 0), 192'(1));
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                check_output("t5_y", y4, exp);
            end
            received++;
        end
    endtask

    initial begin
        int waited;
        int received;
        bit accepted;
        bit was_ready;
        longint last_acc;
        logic [95:0] ra;
        logic [95:0] rb;
        localparam int NOPS = 150;

        srst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        for (int s = 0; s < 5; s++) begin
            a_in[s] = '0;
            b_in[s] = '0;
        end
        repeat (3) tick();
        srst = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check_output($sformatf("reset_in_ready_%0d", s), 192'(in_ready[s]), 192'(1));
            check_output($sformatf("reset_out_valid_%0d", s), 192'(out_valid[s]), 192'(0));
            check_output($sformatf("reset_busy_%0d", s), 192'(busy[s]), 192'(0));
            check_output($sformatf("reset_y_%0d", s), yget(s), 192'(0));
        end

        $display("[TB] truncated 64-bit directed cases");
        apply_stimulus(0, 96'(64'hFFFF_FFFF_FFFF_FFFF), 96'd2, "t1", 1'b1);
        check_output("t1_y_const", yget(0), 192'(64'hFFFF_FFFF_FFFF_FFFE));
        apply_stimulus(0, 96'(64'hFFFF_FFFF_FFFF_FFFD), 96'd7, "t6", 1'b1);
        check_output("t6_y_const", yget(0), 192'(64'hFFFF_FFFF_FFFF_FFEB));
        for (int n = 0; n < 6; n++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            apply_stimulus(0, ra, rb, $sformatf("t64r%0d", n), 1'b1);
        end

        $display("[TB] full 64-bit cases");
        apply_stimulus(1, 96'(64'hFFFF_FFFF_FFFF_FFFF), 96'(64'hFFFF_FFFF_FFFF_FFFF), "t2", 1'b1);
        check_output("t2_y_const", yget(1), 192'(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001));
        for (int n = 0; n < 6; n++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            apply_stimulus(1, ra, rb, $sformatf("f64r%0d", n), 1'b1);
        end

        $display("[TB] 16-bit single-product case with held output");
        apply_stimulus(2, 96'h1234, 96'h0010, "t3", 1'b0);
        for (int n = 0; n < 5; n++) begin
            in_valid[2] = 1'b1;
            a_in[2] = 96'hFFFF;
            b_in[2] = 96'hFFFF;
            tick();
            check_output($sformatf("t3_hold_y_%0d", n), yget(2), 192'h2340);
            check_output($sformatf("t3_hold_valid_%0d", n), 192'(out_valid[2]), 192'(1));
            check_output($sformatf("t3_hold_in_ready_%0d", n), 192'(in_ready[2]), 192'(0));
        end
        in_valid[2] = 1'b0;
        out_ready[2] = 1'b1;
        tick();
        out_ready[2] = 1'b0;
        check_output("t3_release_valid", 192'(out_valid[2]), 192'(0));
        check_output("t3_release_busy", 192'(busy[2]), 192'(0));
        check_output("t3_release_y_kept", yget(2), 192'h2340);

        $display("[TB] 32-bit reset mid-operation");
        a_in[3] = 96'h10000;
        b_in[3] = 96'h10000;
        in_valid[3] = 1'b1;
        tick();
        in_valid[3] = 1'b0;
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check_output("t4_rst_in_ready", 192'(in_ready[3]), 192'(1));
        check_output("t4_rst_out_valid", 192'(out_valid[3]), 192'(0));
        check_output("t4_rst_busy", 192'(busy[3]), 192'(0));
        check_output("t4_rst_y", yget(3), 192'(0));
        repeat (4) tick();
        check_output("t4_abandoned", 192'(out_valid[3]), 192'(0));
        apply_stimulus(3, 96'd3, 96'd5, "t4b", 1'b1);
        check_output("t4b_y_const", yget(3), 192'd15);

        $display("[TB] 96-bit full back-to-back run");
        out_ready[4] = 1'b1;
        received = 0;
        last_acc = -1;
        for (int n = 0; n < NOPS; n++) begin
            if (n == 0) begin
                ra = '1;
                rb = '1;
            end else if (n == 1) begin
                ra = '0;
                rb = {$urandom, $urandom, $urandom};
            end else begin
                ra = {$urandom, $urandom, $urandom};
                rb = {$urandom, $urandom, $urandom};
            end
            sb_q.push_back(model(4, ra, rb));
            a_in[4] = ra;
            b_in[4] = rb;
            in_valid[4] = 1'b1;
            accepted = 1'b0;
            waited = 0;
            while (!accepted && waited < 200) begin
                was_ready = in_ready[4];
                step96(received);
                waited++;
                if (was_ready) accepted = 1'b1;
            end
            check_output($sformatf("t5_accept_%0d", n), 192'(accepted), 192'(1));
            if (accepted && last_acc >= 0)
                check_output($sformatf("t5_interval_%0d", n), 192'(cycle_cnt - last_acc), 192'(38));
            last_acc = cycle_cnt;
        end
        in_valid[4] = 1'b0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 200) begin
            step96(received);
            waited++;
        end
        repeat (45) step96(received);
        check_output("t5_queue_empty", 192'(sb_q.size()), 192'(0));
        check_output("t5_received", 192'(received), 192'(NOPS));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
